// File: rtl/bus_pkg.sv
// Shared definitions for the system bus arbiter: chip-select bit indices,
// default slow-slave mask, FSM state encoding and access-mode constants.
package bus_pkg;

  localparam int CE_UROM = 0;
  localparam int CE_SRAM = 1;
  localparam int CE_UART = 2;
  localparam int CE_ERAM = 3;

  localparam logic [7:0] SLOW_MASK_DEF = 8'b0000_1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GNT  = 2'd2
  } state_t;

  localparam logic [1:0] HB_WORD = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_BYTE = 2'b10;

  function automatic logic is_slow(input logic [7:0] ce, input logic [7:0] mask);
    return |(ce & mask);
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_owner,
// wrapping modulo NUM_MASTERS.
module rr_pick #(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [1:0]             last,
  output logic [1:0]             winner,
  output logic                   valid
);

  logic [3:0] req_pad;
  logic [1:0] idx;

  always_comb begin
    req_pad = 4'(req);
    idx     = '0;
    winner  = last;
    valid   = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = 2'((int'(last) + i) % NUM_MASTERS);
      if (!valid && req_pad[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin system bus arbiter with slow-slave wait states and a zero-latency
// fast path for master 0. Define ARB_LOCK_EN to add m_lock_i burst locking.
//
//   state | meaning
//   IDLE  | no arbitrated transfer; master 0 fast path may be active
//   WAIT  | owner registered, counting slave wait states, no grant yet
//   GNT   | one-cycle grant pulse to owner, then back to IDLE
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int         NUM_MASTERS = 2,
  parameter logic [7:0] SLOW_MASK   = SLOW_MASK_DEF,
  parameter int         WAIT_CYCLES = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_MASTERS-1:0]   m_req_i,
  input  logic [8*NUM_MASTERS-1:0] m_ce_i,
  input  logic [NUM_MASTERS-1:0]   m_we_i,
  input  logic [2*NUM_MASTERS-1:0] m_hb_i,
  input  logic [32*NUM_MASTERS-1:0] m_addr_i,
  input  logic [32*NUM_MASTERS-1:0] m_wdata_i,
`ifdef ARB_LOCK_EN
  input  logic [NUM_MASTERS-1:0]   m_lock_i,
`endif
  output logic [NUM_MASTERS-1:0]   m_gnt_o,
  output logic [7:0]               s_ce_o,
  output logic                     s_we_o,
  output logic [1:0]               s_hb_o,
  output logic [31:0]              s_addr_o,
  output logic [31:0]              s_wdata_o,
  output logic [1:0]               owner_o,
  output logic                     busy_o
);

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [3:0]  req_pad;
  logic [3:0]  slow_v;
  logic [7:0]  ce_a    [4];
  logic        we_a    [4];
  logic [1:0]  hb_a    [4];
  logic [31:0] addr_a  [4];
  logic [31:0] wdata_a [4];

  logic        fast, drive, gnt_fire, win_valid;
  logic [1:0]  src, win, pick;

`ifdef ARB_LOCK_EN
  logic [3:0]  lock_pad;
  logic        lock_pend_q, lock_pend_d;
  logic        lock_used_q, lock_used_d;
  logic [3:0]  streak_q, streak_d;
  logic        lock_hit;
`endif

  // Pad per-master fields to four slots so owner indexing never runs out of range.
  always_comb begin
    req_pad = 4'(m_req_i);
    for (int i = 0; i < 4; i++) begin
      ce_a[i]    = '0;
      we_a[i]    = 1'b0;
      hb_a[i]    = '0;
      addr_a[i]  = '0;
      wdata_a[i] = '0;
      slow_v[i]  = 1'b0;
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      ce_a[i]    = m_ce_i[8*i +: 8];
      we_a[i]    = m_we_i[i];
      hb_a[i]    = m_hb_i[2*i +: 2];
      addr_a[i]  = m_addr_i[32*i +: 32];
      wdata_a[i] = m_wdata_i[32*i +: 32];
      slow_v[i]  = is_slow(m_ce_i[8*i +: 8], SLOW_MASK);
    end
  end

  rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_rr_pick (
    .req    (m_req_i),
    .last   (last_q),
    .winner (win),
    .valid  (win_valid)
  );

`ifdef ARB_LOCK_EN
  assign lock_pad = 4'(m_lock_i);
  assign lock_hit = lock_pend_q && req_pad[last_q] && (streak_q < 4'd8);
  assign pick     = lock_hit ? last_q : win;
`else
  assign pick     = win;
`endif

  // Fast path is gated by reset so every output is quiet while rst_ni is low.
  assign fast = rst_ni && (state_q == IDLE) && req_pad[0] && !slow_v[0];

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    drive    = 1'b0;
    src      = 2'd0;
    gnt_fire = 1'b0;
`ifdef ARB_LOCK_EN
    lock_pend_d = lock_pend_q;
    lock_used_d = lock_used_q;
    streak_d    = streak_q;
`endif
    case (state_q)
      IDLE: begin
        if (fast) begin
          drive    = 1'b1;
          gnt_fire = 1'b1;
        end else if (win_valid) begin
          owner_d = pick;
`ifdef ARB_LOCK_EN
          lock_pend_d = 1'b0;
          lock_used_d = lock_hit;
`endif
          if (slow_v[pick]) begin
            if (WAIT_CYCLES == 0) begin
              state_d = GNT;
            end else begin
              cnt_d   = 4'(WAIT_CYCLES);
              state_d = WAIT;
            end
          end else begin
            state_d = GNT;
          end
        end
      end
      WAIT: begin
        drive = 1'b1;
        src   = owner_q;
        cnt_d = cnt_q - 4'd1;
        if (!req_pad[owner_q]) begin
          state_d = IDLE;
        end else if (cnt_q <= 4'd1) begin
          state_d = GNT;
        end
      end
      GNT: begin
        drive    = 1'b1;
        src      = owner_q;
        gnt_fire = 1'b1;
        last_d   = owner_q;
        state_d  = IDLE;
`ifdef ARB_LOCK_EN
        lock_pend_d = lock_pad[owner_q];
        streak_d    = lock_used_q ? (streak_q + 4'd1) : 4'd1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= 2'(NUM_MASTERS - 1);
      cnt_q   <= '0;
`ifdef ARB_LOCK_EN
      lock_pend_q <= 1'b0;
      lock_used_q <= 1'b0;
      streak_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
`ifdef ARB_LOCK_EN
      lock_pend_q <= lock_pend_d;
      lock_used_q <= lock_used_d;
      streak_q    <= streak_d;
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_gnt_o[i] = gnt_fire && (src == 2'(i));
    end
    s_ce_o    = '0;
    s_we_o    = 1'b0;
    s_hb_o    = '0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    if (drive) begin
      s_ce_o    = ce_a[src];
      s_we_o    = we_a[src];
      s_hb_o    = hb_a[src];
      s_addr_o  = addr_a[src];
      s_wdata_o = wdata_a[src];
    end
  end

  assign owner_o = owner_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Shares the single system bus (chip-selected slaves: boot ROM, SRAM, UART, external RAM) between the core's load/store unit and up to three further masters such as a DMA or debug port. It arbitrates round-robin and muxes the winner's address, data and control onto the slave side. It inserts slave-specific wait states and returns a one-cycle grant pulse, which releases the requester's stall. Master 0 is always the core's load/store path; it keeps a zero-latency path to fast slaves so non-stalling accesses remain single-cycle.

Parameters:
NUM_MASTERS, 2, number of requesters (2..4); master 0 = core LSU
SLOW_MASK, 8'b0000_1010, chip-select bits that require arbitration plus wait states (SRAM, external RAM)
WAIT_CYCLES, 2, wait states inserted before grant for slow slaves (0..15)

Ports:
clk_i  in  1  system clock, rising edge
rst_ni  in  1  asynchronous active-low reset
m_req_i  in  NUM_MASTERS  per-master bus request, held until grant
m_ce_i  in  8*NUM_MASTERS  per-master one-hot chip select
m_we_i  in  NUM_MASTERS  per-master write enable
m_hb_i  in  2*NUM_MASTERS  per-master half/byte/word mode
m_addr_i  in  32*NUM_MASTERS  per-master address
m_wdata_i  in  32*NUM_MASTERS  per-master write data
m_gnt_o  out  NUM_MASTERS  per-master grant, one-hot or zero
s_ce_o  out  8  muxed chip select to slaves
s_we_o  out  1  muxed write enable
s_hb_o  out  2  muxed access mode
s_addr_o  out  32  muxed address
s_wdata_o  out  32  muxed write data
owner_o  out  2  index of the current bus owner (valid when busy_o=1)
busy_o  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values:
  - state=IDLE, counter=0, last_owner=NUM_MASTERS-1 (master 0 wins first), owner=0.
  - All outputs are 0 while reset is asserted.
- Slow access: (m_ce & SLOW_MASK) != 0. A zero chip select counts as fast.
- Fast path:
  - Applies only in IDLE, when m_req_i[0]=1 and master 0's access is fast.
  - Slave bus is driven from master 0 combinationally and m_gnt_o[0]=1 in the same cycle.
  - FSM stays in IDLE. Other masters are not arbitrated that cycle.
- IDLE state:
  - If there are no requests, or only the fast-path case applies, the slave outputs follow the fast path or are all 0.
  - Otherwise, pick the lowest-index requester starting at last_owner+1 (wrapping modulo NUM_MASTERS) and register it as owner.
    - Slow access → load counter with WAIT_CYCLES, go to WAIT. If WAIT_CYCLES=0, go directly to GNT.
    - Fast access from master ≥1 → go to GNT.
- WAIT state:
  - Slave outputs are driven from owner; m_gnt_o=0.
  - Counter decrements each cycle; at 1 → GNT.
  - If m_req_i[owner] drops: abort to IDLE, no grant issued, last_owner unchanged.
- GNT state:
  - Slave outputs are driven from owner; m_gnt_o[owner]=1 for exactly one cycle.
  - last_owner<=owner; next state IDLE.
- Latency: slow access = 1 arbitration cycle + WAIT_CYCLES + 1 grant cycle. Default WAIT_CYCLES=2 gives grant in the 4th cycle after the request is sampled.
- Invariants:
  - m_gnt_o is never multi-hot.
  - Slave outputs are never driven by a non-owner outside the fast path.
- Owner index: owner_o zero-extends the owner index to 2 bits.
- Request inputs: requests from index ≥ NUM_MASTERS do not exist.
- Reset mid-transfer: immediate return to IDLE, grant dropped, no partial grant afterwards.

Optional Feature:
ARB_LOCK_EN:
- Defined:
  - Adds input m_lock_i [NUM_MASTERS].
  - If m_lock_i[owner]=1 during GNT, the next IDLE arbitration selects the same owner if it requests, overriding round-robin. This allows back-to-back burst beats.
  - A lock is honoured for at most 8 consecutive grants, then round-robin is forced for one arbitration.
- Undefined: the port is absent and plain round-robin applies.

Decomposition:
- Shared package bus_pkg:
  - chip-select bit indices (CE_UROM=0, CE_SRAM=1, CE_UART=2, CE_ERAM=3)
  - default SLOW_MASK
  - state encoding IDLE=2'd0, WAIT=2'd1, GNT=2'd2
  - hb mode constants
- One sub-module, rr_pick: combinational round-robin picker. Inputs are the request vector and last_owner; outputs are the winner index and a valid flag.

Test Plan:
- Master 0 fast access: req0=1, ce=8'h01 → m_gnt_o=01 in the same cycle, s_addr_o=m_addr0, busy_o stays 0.
- Master 1 slow access: req1=1, ce=8'h02, WAIT_CYCLES=2 → busy_o set, m_gnt_o=10 in the 4th cycle, held for exactly one cycle, then IDLE.
- Contention: req0 and req1 both slow, held continuously → grants alternate 0,1,0,1. Reset state gives master 0 first.
- Abort: master 1 slow request dropped after 1 WAIT cycle → no grant, FSM returns to IDLE, next arbitration still starts at master 0.
- Async reset: rst_ni low during WAIT → all outputs 0 immediately; after release the first grant goes to master 0.
- With ARB_LOCK_EN: master 1 locked, both requesting → master 1 receives 8 consecutive grants, then master 0 is granted once.
